dram_bank_responder: RTL and testbench

Command-side responder for the DRAM controller's bank interface, acting as the memory end of the protocol. It accepts `cmd_req`/`cmd` with one-hot bank/row/column selects and answers with a one-cycle `cmd_ack` after the command's timing interval. It tracks an open row per bank and stores data in an internal behavioural array. Read data is driven out on the serial data bit; write data is captured from it. It serves as the bench-side and FPGA-side counterpart of the controller.

---
 rtl/dram_bank_responder.sv | 178 +++++++++++++++++
 tb/tb_dram_bank_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_responder.sv
// dram_bank_responder: memory-side end of the DRAM controller bank interface.
// Accepts one command at a time, models the ACTIVATE/PRECHARGE/REFRESH
// timing, tracks an open row per bank and serves serial MSB-first column
// reads and writes from a behavioural array.
// Optional build macro: DRAM_BANK_RSP_ERR_CHECK_EN enables protocol checks
// and the sticky err flag; when undefined err is tied low.
module dram_bank_responder #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int T_RCD        = 3,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 8
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    cmd_req,
  input  logic [1:0]              cmd,
  input  logic                    bank_rw,
  input  logic [NUM_OF_BANKS-1:0] bank_sel,
  input  logic [NUM_OF_ROWS-1:0]  row_sel,
  input  logic [NUM_OF_COLS-1:0]  col_sel,
  input  logic                    dram_data_in,
  output logic                    dram_data_out,
  output logic                    dram_data_oe,
  output logic                    cmd_ack,
  output logic                    busy,
  output logic                    err
);

  localparam int BW   = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int RW   = (NUM_OF_ROWS  > 1) ? $clog2(NUM_OF_ROWS)  : 1;
  localparam int CW   = (NUM_OF_COLS  > 1) ? $clog2(NUM_OF_COLS)  : 1;
  localparam int MAXA = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int MAXB = (T_RFC > DATA_WIDTH) ? T_RFC : DATA_WIDTH;
  localparam int MAXT = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int CNTW = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_PRE, S_REF, S_RD, S_WR, S_ACK, S_REL
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNTW-1:0]       r_cnt;
  logic                  r_err, r_cmd_err;
  logic [NUM_OF_BANKS-1:0] r_open_valid;
  logic [RW-1:0]         r_open_row [NUM_OF_BANKS];
  logic [BW-1:0]         r_bank;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_mem [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS];

  logic [BW-1:0]         w_bank_idx;
  logic [RW-1:0]         w_row_idx;
  logic [CW-1:0]         w_col_idx;
  logic                  w_accept, w_timed, w_last, w_cmd_err;
  logic [DATA_WIDTH-1:0] w_shift_in;

  // Lowest set bit wins, so a malformed select still maps to a legal index.
  function automatic logic [BW-1:0] lsb_bank(input logic [NUM_OF_BANKS-1:0] v);
    logic [BW-1:0] idx = '0;
    for (int i = NUM_OF_BANKS - 1; i >= 0; i--) if (v[i]) idx = BW'(i);
    return idx;
  endfunction

  function automatic logic [RW-1:0] lsb_row(input logic [NUM_OF_ROWS-1:0] v);
    logic [RW-1:0] idx = '0;
    for (int i = NUM_OF_ROWS - 1; i >= 0; i--) if (v[i]) idx = RW'(i);
    return idx;
  endfunction

  function automatic logic [CW-1:0] lsb_col(input logic [NUM_OF_COLS-1:0] v);
    logic [CW-1:0] idx = '0;
    for (int i = NUM_OF_COLS - 1; i >= 0; i--) if (v[i]) idx = CW'(i);
    return idx;
  endfunction

  assign w_bank_idx = lsb_bank(bank_sel);
  assign w_row_idx  = lsb_row(row_sel);
  assign w_col_idx  = lsb_col(col_sel);
  assign w_accept   = (r_state == S_IDLE) && cmd_req;
  assign w_timed    = (r_state == S_ACT) || (r_state == S_PRE) || (r_state == S_REF) ||
                      (r_state == S_RD)  || (r_state == S_WR);
  assign w_shift_in = {r_shift[DATA_WIDTH-2:0], dram_data_in};

`ifdef DRAM_BANK_RSP_ERR_CHECK_EN
  // Protocol violations detected against the command being accepted.
  always_comb begin
    w_cmd_err = !$onehot(bank_sel);
    case (cmd)
      2'b01:   w_cmd_err = w_cmd_err || !$onehot(row_sel) || r_open_valid[w_bank_idx];
      2'b10:   w_cmd_err = w_cmd_err || !$onehot(col_sel) || !r_open_valid[w_bank_idx];
      2'b11:   w_cmd_err = w_cmd_err || (|r_open_valid);
      default: w_cmd_err = w_cmd_err;
    endcase
  end
`else
  assign w_cmd_err = 1'b0;
`endif

  // End of the timed interval for the current busy state.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_ACT:   w_last = (r_cnt == CNTW'(T_RCD - 1));
      S_PRE:   w_last = (r_cnt == CNTW'(T_RP - 1));
      S_REF:   w_last = (r_cnt == CNTW'(T_RFC - 1));
      S_RD,
      S_WR:    w_last = (r_cnt == CNTW'(DATA_WIDTH - 1));
      default: w_last = 1'b0;
    endcase
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_nxt   = r_state;
    busy          = (r_state != S_IDLE);
    cmd_ack       = (r_state == S_ACK);
    dram_data_oe  = (r_state == S_RD);
    dram_data_out = (r_state == S_RD) && r_shift[DATA_WIDTH-1];
    err           = r_err;
    case (r_state)
      S_IDLE: if (cmd_req) begin
        case (cmd)
          2'b00:   w_state_nxt = S_PRE;
          2'b01:   w_state_nxt = S_ACT;
          2'b10:   w_state_nxt = bank_rw ? S_WR : S_RD;
          default: w_state_nxt = S_REF;
        endcase
      end
      S_ACT, S_PRE, S_REF, S_RD, S_WR: if (w_last) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_REL;
      S_REL:   if (!cmd_req) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, interval counter, error flags and open-bank map.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_open_valid <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_timed && !w_last) ? r_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_cmd_err <= w_cmd_err;
        r_err     <= r_err || w_cmd_err;
      end
      if (w_last && !r_cmd_err && (r_state == S_ACT)) r_open_valid[r_bank] <= 1'b1;
      if (w_last && !r_cmd_err && (r_state == S_PRE)) r_open_valid[r_bank] <= 1'b0;
      if (w_last && (r_state == S_REF)) r_open_valid <= '0;
    end
  end

  // Datapath: latched indices, open-row table, shift register and array.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bank <= w_bank_idx;
      r_row  <= w_row_idx;
      r_col  <= w_col_idx;
      if ((cmd == 2'b10) && !bank_rw)
        r_shift <= w_cmd_err ? '0 : r_mem[w_bank_idx][r_open_row[w_bank_idx]][w_col_idx];
    end
    if (r_state == S_RD) r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
    if (r_state == S_WR) begin
      r_shift <= w_shift_in;
      if (w_last && !r_cmd_err) r_mem[r_bank][r_open_row[r_bank]][r_col] <= w_shift_in;
    end
    if ((r_state == S_ACT) && w_last && !r_cmd_err) r_open_row[r_bank] <= r_row;
  end

endmodule

// File: tb/tb_dram_bank_responder.sv
// Self-checking bench for dram_bank_responder: table of commands applied
// through a scoreboard, plus hand-written hold, refresh and reset sequences.
module tb_dram_bank_responder;
  localparam int NB = 8, NR = 128, NC = 8, DW = 8;
  localparam int TRCD = 3, TRP = 2, TRFC = 8;

  logic          clk = 1'b0;
  logic          rst_b, cmd_req, bank_rw, dram_data_in;
  logic [1:0]    cmd;
  logic [NB-1:0] bank_sel;
  logic [NR-1:0] row_sel;
  logic [NC-1:0] col_sel;
  logic          dram_data_out, dram_data_oe, cmd_ack, busy, err;

  dram_bank_responder #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .DATA_WIDTH(DW),
    .T_RCD(TRCD), .T_RP(TRP), .T_RFC(TRFC)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd), .bank_rw(bank_rw),
    .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
    .dram_data_in(dram_data_in), .dram_data_out(dram_data_out),
    .dram_data_oe(dram_data_oe), .cmd_ack(cmd_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [1:0]    cmd;
    bit            rw;
    int            bank;
    int            row;
    int            col;
    logic [DW-1:0] wdata;
  } vec_t;

  typedef struct {
    int            lat;
    logic [DW-1:0] rdata;
    bit            is_rd;
  } exp_t;

  exp_t          sb[$];
  bit            m_open[NB];
  int            m_row[NB];
  logic [DW-1:0] m_mem[int];
  bit            m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] c, input bit rw, input int b,
                              input int r, input int col, input logic [DW-1:0] w);
    vec_t v;
    v.cmd = c; v.rw = rw; v.bank = b; v.row = r; v.col = col; v.wdata = w;
    return v;
  endfunction

  // Reference behaviour: compute latency/read data and update the model.
  task automatic model_push(input vec_t v);
    exp_t x;
    bit   e;
    bit   any_open;
    int   key;
    e = 1'b0;
    any_open = 1'b0;
    for (int i = 0; i < NB; i++) any_open |= m_open[i];
`ifdef DRAM_BANK_RSP_ERR_CHECK_EN
    case (v.cmd)
      2'b01:   e = m_open[v.bank];
      2'b10:   e = !m_open[v.bank];
      2'b11:   e = any_open;
      default: e = 1'b0;
    endcase
`endif
    x.is_rd = (v.cmd == 2'b10) && !v.rw;
    x.rdata = '0;
    key = v.bank * 100000 + m_row[v.bank] * 100 + v.col;
    case (v.cmd)
      2'b00: begin x.lat = TRP + 1; if (!e) m_open[v.bank] = 1'b0; end
      2'b01: begin
        x.lat = TRCD + 1;
        if (!e) begin m_open[v.bank] = 1'b1; m_row[v.bank] = v.row; end
      end
      2'b10: begin
        x.lat = DW + 1;
        if (v.rw) begin
          if (!e) m_mem[key] = v.wdata;
        end else if (!e) begin
          x.rdata = m_mem.exists(key) ? m_mem[key] : 'x;
        end
      end
      default: begin x.lat = TRFC + 1; for (int i = 0; i < NB; i++) m_open[i] = 1'b0; end
    endcase
    m_err |= e;
    sb.push_back(x);
  endtask

  // Drive one command, observe its completion and compare with the scoreboard.
  task automatic run_cmd(input vec_t v, input int hold);
    exp_t          x;
    int            k;
    int            nbits;
    bit            got;
    logic [DW-1:0] rd;
    chk("idle_before_cmd", busy, 1'b0);
    cmd      = v.cmd;
    bank_rw  = v.rw;
    bank_sel = NB'(1) << v.bank;
    row_sel  = NR'(1) << v.row;
    col_sel  = NC'(1) << v.col;
    cmd_req  = 1'b1;
    model_push(v);
    @(posedge clk); #1;
    k = 1; nbits = 0; got = 1'b0; rd = '0;
    while (k <= 60 && !got) begin
      if (cmd_ack) got = 1'b1;
      else begin
        if (dram_data_oe) begin rd = {rd[DW-2:0], dram_data_out}; nbits++; end
        if (v.cmd == 2'b10 && v.rw && k <= DW) dram_data_in = v.wdata[DW-k];
        @(posedge clk); #1;
        k++;
      end
    end
    x = sb.pop_front();
    if (!got) begin
      n_tot++;
      $display("FAIL ack_timeout: no cmd_ack within %0d cycles, expected at %0d", k, x.lat);
    end else begin
      chk("ack_latency", k, x.lat);
    end
    chk("oe_bit_count", nbits, x.is_rd ? DW : 0);
    if (x.is_rd) chk("read_data", rd, x.rdata);
    chk("err_flag", err, m_err);
    @(posedge clk); #1;
    chk("ack_one_cycle", cmd_ack, 1'b0);
    for (int h = 0; h < hold; h++) begin
      chk("busy_while_held", busy, 1'b1);
      chk("no_reaccept_ack", cmd_ack, 1'b0);
      chk("no_reaccept_oe", dram_data_oe, 1'b0);
      @(posedge clk); #1;
    end
    cmd_req = 1'b0;
    dram_data_in = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_release", busy, 1'b0);
  endtask

  vec_t tbl[10];

  initial begin
    rst_b = 1'b0; cmd_req = 1'b0; cmd = 2'b00; bank_rw = 1'b0;
    bank_sel = '0; row_sel = '0; col_sel = '0; dram_data_in = 1'b0;
    m_err = 1'b0;
    for (int i = 0; i < NB; i++) begin m_open[i] = 1'b0; m_row[i] = 0; end

    tbl[0] = mk(2'b01, 0, 2, 5,   0, 8'h00);
    tbl[1] = mk(2'b10, 1, 2, 0,   3, 8'hA5);
    tbl[2] = mk(2'b10, 0, 2, 0,   3, 8'h00);
    tbl[3] = mk(2'b10, 1, 2, 0,   0, 8'h3C);
    tbl[4] = mk(2'b01, 0, 5, 100, 0, 8'h00);
    tbl[5] = mk(2'b10, 1, 5, 0,   7, 8'h81);
    tbl[6] = mk(2'b10, 0, 2, 0,   0, 8'h00);
    tbl[7] = mk(2'b10, 0, 5, 0,   7, 8'h00);
    tbl[8] = mk(2'b00, 0, 2, 0,   0, 8'h00);
    tbl[9] = mk(2'b00, 0, 5, 0,   0, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", cmd_ack, 1'b0);
    chk("rst_data_out", dram_data_out, 1'b0);
    chk("rst_data_oe", dram_data_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_cmd(tbl[i], 0);

    // Request held high after ack must not start a second command.
    run_cmd(mk(2'b01, 0, 4, 7, 0, 8'h00), 5);
    run_cmd(mk(2'b00, 0, 4, 0, 0, 8'h00), 0);

`ifdef DRAM_BANK_RSP_ERR_CHECK_EN
    // Read of a closed bank: zeros, err set and sticky through legal commands.
    run_cmd(mk(2'b10, 0, 1, 0, 0, 8'h00), 0);
    run_cmd(mk(2'b01, 0, 1, 2, 0, 8'h00), 0);
    run_cmd(mk(2'b00, 0, 1, 0, 0, 8'h00), 0);
`endif

    // Refresh with banks 0 and 7 open closes every bank.
    run_cmd(mk(2'b01, 0, 0, 9, 0, 8'h00), 0);
    run_cmd(mk(2'b10, 1, 0, 0, 1, 8'h5A), 0);
    run_cmd(mk(2'b01, 0, 7, 1, 0, 8'h00), 0);
    run_cmd(mk(2'b10, 1, 7, 0, 2, 8'hC3), 0);
    run_cmd(mk(2'b11, 0, 0, 0, 0, 8'h00), 0);
    run_cmd(mk(2'b10, 0, 0, 0, 1, 8'h00), 0);
    run_cmd(mk(2'b10, 0, 7, 0, 2, 8'h00), 0);

    // Reset in the 4th bit of a write of FF over a location holding 00.
    run_cmd(mk(2'b01, 0, 3, 20, 0, 8'h00), 0);
    run_cmd(mk(2'b10, 1, 3, 0,  6, 8'h00), 0);
    cmd = 2'b10; bank_rw = 1'b1; bank_sel = NB'(1) << 3; col_sel = NC'(1) << 6;
    cmd_req = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      dram_data_in = 1'b1;
      if (k < 4) begin @(posedge clk); #1; end
    end
    #2 rst_b = 1'b0;
    #1;
    chk("midrst_ack", cmd_ack, 1'b0);
    chk("midrst_data_out", dram_data_out, 1'b0);
    chk("midrst_data_oe", dram_data_oe, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_err", err, 1'b0);
    cmd_req = 1'b0; dram_data_in = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_held", busy, 1'b0);
    rst_b = 1'b1;
    m_err = 1'b0;
    for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
    @(posedge clk); #1;
    run_cmd(mk(2'b01, 0, 3, 20, 0, 8'h00), 0);
    run_cmd(mk(2'b10, 0, 3, 0,  6, 8'h00), 0);
    run_cmd(mk(2'b00, 0, 3, 0,  0, 8'h00), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
